// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side signal bundle around the memory arbiter.
// The arbiter takes the slave view; caches and RAM together take the master view.
interface memory_arbiter_if #(
  parameter int WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic              ramready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates icache fills and dcache reads/writes onto one single-port RAM.
// Dcache has priority; a bounded dcache streak keeps the icache from starving.
module memory_arbiter #(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  memory_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     dstreak_q, dstreak_d;
  logic              dreq, starve;
  logic              iwait, dwait, ram_ren, ram_wen;
  logic [WORD_W-1:0] iload, dload, ram_addr, ram_store;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v >= SW'(MAX_DSTREAK)) return SW'(MAX_DSTREAK);
    return v + SW'(1);
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  assign dreq   = bus.dREN | bus.dWEN;
  assign starve = bus.iREN && (dstreak_q == SW'(MAX_DSTREAK));

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    case (state_q)
      IDLE: begin
        if (dreq && !starve) state_d = DGRANT;
        else if (bus.iREN)   state_d = IGRANT;
      end
      IGRANT: begin
        // A dropped request abandons the grant without touching the streak.
        state_d = IDLE;
        if (bus.iREN) begin
          ram_ren  = 1'b1;
          ram_addr = bus.iaddr;
          if (bus.ramready) begin
            iwait     = 1'b0;
            iload     = bus.ramload;
            dstreak_d = '0;
          end else begin
            state_d = IGRANT;
          end
        end
      end
      DGRANT: begin
        state_d = IDLE;
        if (dreq) begin
          ram_addr = bus.daddr;
          if (bus.dWEN) begin
            ram_wen   = 1'b1;
            ram_store = bus.dstore;
          end else begin
            ram_ren = 1'b1;
          end
          if (bus.ramready) begin
            dwait     = 1'b0;
            dload     = bus.dWEN ? '0 : bus.ramload;
            dstreak_d = bus.iREN ? sat_inc(dstreak_q) : '0;
          end else begin
            state_d = DGRANT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.iwait    = iwait;
  assign bus.iload    = iload;
  assign bus.dwait    = dwait;
  assign bus.dload    = dload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// traffic compared every cycle against an owner/streak reference model.
module tb_memory_arbiter;
  localparam int W    = 32;
  localparam int MAXS = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  memory_arbiter_if #(.WORD_W(W)) bus ();

  memory_arbiter #(.WORD_W(W), .MAX_DSTREAK(MAXS)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache) and how many
  // dcache grants in a row were served while the icache was waiting.
  int m_owner = 0, m_streak = 0, nx_owner = 0, nx_streak = 0;

  int          rdy_delay = 0, rdy_cnt = 0;
  bit          idle_noise = 0, fixed_load = 0;
  logic [W-1:0] load_val = '0;
  bit          idone, ddone;
  logic [W-1:0] comp_addr_q[$];
  int          grant_q[$];
  logic        comp_wen, comp_ren;
  logic [W-1:0] comp_store, comp_load;

  task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic          e_iwait, e_dwait, e_ren, e_wen;
    logic [W-1:0]  e_iload, e_dload, e_addr, e_store;
    bit            dreq;
    e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
    e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
    if (!nRST) begin m_owner = 0; m_streak = 0; end
    dreq      = bus.dREN | bus.dWEN;
    nx_owner  = 0;
    nx_streak = m_streak;
    if (m_owner == 0) begin
      if (dreq && !(bus.iREN && m_streak == MAXS)) nx_owner = 2;
      else if (bus.iREN)                           nx_owner = 1;
    end else if (m_owner == 1 && bus.iREN) begin
      e_ren = 1; e_addr = bus.iaddr;
      if (bus.ramready) begin e_iwait = 0; e_iload = bus.ramload; nx_streak = 0; end
      else nx_owner = 1;
    end else if (m_owner == 2 && dreq) begin
      e_addr = bus.daddr;
      if (bus.dWEN) begin e_wen = 1; e_store = bus.dstore; end
      else e_ren = 1;
      if (bus.ramready) begin
        e_dwait   = 0;
        e_dload   = bus.dWEN ? '0 : bus.ramload;
        nx_streak = bus.iREN ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else nx_owner = 2;
    end
    if (!nRST) begin nx_owner = 0; nx_streak = 0; end
    check_val("iwait", W'(bus.iwait), W'(e_iwait));
    check_val("dwait", W'(bus.dwait), W'(e_dwait));
    check_val("iload", bus.iload, e_iload);
    check_val("dload", bus.dload, e_dload);
    check_val("ramREN", W'(bus.ramREN), W'(e_ren));
    check_val("ramWEN", W'(bus.ramWEN), W'(e_wen));
    check_val("ramaddr", bus.ramaddr, e_addr);
    check_val("ramstore", bus.ramstore, e_store);
    check_val("one_strobe", W'(bus.ramREN & bus.ramWEN), '0);
    check_val("one_wait", W'(!bus.iwait & !bus.dwait), '0);
  endtask

  // Caller sets request inputs just after a rising edge; this plays the RAM,
  // checks at the falling edge and advances the model at the next rising edge.
  task automatic tick();
    #1;
    if (bus.ramREN | bus.ramWEN) begin
      bus.ramready = (rdy_cnt >= rdy_delay);
      rdy_cnt++;
    end else begin
      bus.ramready = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy_cnt = 0;
    end
    bus.ramload = fixed_load ? load_val : $urandom;
    @(negedge CLK);
    model_check();
    idone = (bus.iwait === 1'b0);
    ddone = (bus.dwait === 1'b0);
    if (idone || ddone) begin
      grant_q.push_back(idone ? 1 : 2);
      comp_addr_q.push_back(bus.ramaddr);
      comp_wen = bus.ramWEN; comp_ren = bus.ramREN;
      comp_store = bus.ramstore; comp_load = idone ? bus.iload : bus.dload;
    end
    @(posedge CLK);
    #1;
    m_owner  = nx_owner;
    m_streak = nx_streak;
    if (idone || ddone) rdy_cnt = 0;
  endtask

  int k;
  int exp_g[7] = '{2, 2, 2, 2, 1, 2, 2};
  int d_left;
  bit i_fin, d_fin;

  initial begin
    nRST = 0;
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramready = 0;

    // Reset held for three cycles with outputs idle
    repeat (3) tick();
    nRST = 1;
    tick();

    // Icache read, RAM answers two cycles after the strobe
    bus.iREN = 1; bus.iaddr = 32'h10; rdy_delay = 2;
    fixed_load = 1; load_val = 32'h0108DDFA;
    k = 0;
    do begin tick(); k++; end while (!idone && k < 20);
    check_val("i_done", W'(idone), W'(1));
    check_val("i_latency", W'(k), W'(4));
    check_val("i_load", comp_load, 32'h0108DDFA);
    bus.iREN = 0; fixed_load = 0;
    tick();

    // Minimum-latency dcache read
    bus.dREN = 1; bus.daddr = 32'h44; rdy_delay = 0;
    k = 0;
    do begin tick(); k++; end while (!ddone && k < 20);
    check_val("d_min_latency", W'(k), W'(2));
    bus.dREN = 0;
    tick();

    // Collision: dcache first, then icache after an idle cycle
    comp_addr_q.delete(); grant_q.delete();
    bus.iREN = 1; bus.iaddr = 32'h100; bus.dREN = 1; bus.daddr = 32'h40; rdy_delay = 1;
    i_fin = 0; d_fin = 0; k = 0;
    while (!(i_fin && d_fin) && k < 40) begin
      tick(); k++;
      if (ddone) begin d_fin = 1; bus.dREN = 0; end
      if (idone) begin i_fin = 1; bus.iREN = 0; end
    end
    check_val("coll_count", W'(comp_addr_q.size()), W'(2));
    if (comp_addr_q.size() == 2) begin
      check_val("coll_addr0", comp_addr_q[0], 32'h40);
      check_val("coll_addr1", comp_addr_q[1], 32'h100);
      check_val("coll_first", W'(grant_q[0]), W'(2));
    end

    // Dcache write
    bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF; rdy_delay = 1;
    k = 0;
    do begin tick(); k++; end while (!ddone && k < 20);
    check_val("w_done", W'(ddone), W'(1));
    check_val("w_wen", W'(comp_wen), W'(1));
    check_val("w_ren", W'(comp_ren), W'(0));
    check_val("w_store", comp_store, 32'hDEADBEEF);
    bus.dWEN = 0;
    tick();

    // Starvation limit: icache held while dcache streams six reads
    grant_q.delete();
    bus.iREN = 1; bus.iaddr = 32'h200; bus.dREN = 1; bus.daddr = 32'h400; rdy_delay = 0;
    d_left = 6; i_fin = 0; k = 0;
    while (!(i_fin && d_left == 0) && k < 100) begin
      tick(); k++;
      if (ddone) begin
        d_left--; bus.daddr = bus.daddr + 4;
        if (d_left == 0) bus.dREN = 0;
      end
      if (idone) begin i_fin = 1; bus.iREN = 0; end
    end
    check_val("starve_count", W'(grant_q.size()), W'(7));
    for (int i = 0; i < 7 && i < grant_q.size(); i++)
      check_val($sformatf("starve_grant%0d", i), W'(grant_q[i]), W'(exp_g[i]));

    // Reset mid-DGRANT aborts at once; ramready while idle is ignored
    tick();
    bus.dREN = 1; bus.daddr = 32'h300; rdy_delay = 3;
    tick(); tick();
    nRST = 0;
    m_owner = 0; m_streak = 0;
    #1;
    check_val("abort_ren", W'(bus.ramREN), W'(0));
    check_val("abort_addr", bus.ramaddr, '0);
    check_val("abort_dwait", W'(bus.dwait), W'(1));
    idle_noise = 1;
    repeat (3) tick();
    nRST = 1;
    grant_q.delete();
    rdy_delay = 1; k = 0;
    do begin tick(); k++; end while (!ddone && k < 20);
    check_val("abort_regrant", W'(ddone), W'(1));
    check_val("abort_latency", W'(k), W'(3));
    bus.dREN = 0;
    tick();

    // Randomized traffic with withdrawals and stray ramready pulses
    for (int c = 0; c < 3000; c++) begin
      rdy_delay = $urandom_range(0, 3);
      tick();
      if (idone || (bus.iREN && $urandom_range(0, 31) == 0)) bus.iREN = 0;
      else if (!bus.iREN && $urandom_range(0, 3) == 0) begin
        bus.iREN = 1; bus.iaddr = $urandom;
      end
      if (ddone || ((bus.dREN | bus.dWEN) && $urandom_range(0, 31) == 0)) begin
        bus.dREN = 0; bus.dWEN = 0;
      end else if (!(bus.dREN | bus.dWEN) && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        bus.dREN = (k != 1); bus.dWEN = (k != 0);
        bus.daddr = $urandom; bus.dstore = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
